// File: rtl/bp_be_accel_xor_array.sv
// Weight-stationary XOR core: two weight banks, activations XORed with a
// bank and drained as fill-width beats, low beat first.
module bp_be_accel_xor_array #(
    parameter int block_width_p = 512,
    parameter int data_width_p  = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [1:0]               op_i,
    input  logic [block_width_p-1:0] data_i,
    input  logic                     v_i,
    output logic                     ready_o,
    output logic [data_width_p-1:0]  data_o,
    output logic                     v_o,
    input  logic                     yumi_i,
    output logic                     busy_o
);
    localparam int beats_lp     = block_width_p / data_width_p;
    localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e                                state_q, state_d;
    logic [cnt_width_lp-1:0]               cnt_q, cnt_d;
    logic [beats_lp-1:0][data_width_p-1:0] result_q, result_d;
    logic [block_width_p-1:0]              wt0_q, wt0_d;
    logic [block_width_p-1:0]              wt1_q, wt1_d;
    logic                                  last_beat;
    logic                                  fire;

    assign last_beat = (cnt_q == cnt_width_lp'(beats_lp - 1));
    assign fire      = v_i & ready_o;
    assign data_o    = result_q[cnt_q];

    always_comb begin
        ready_o = 1'b0;
        v_o     = 1'b0;
        busy_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            DRAIN: begin
                v_o     = 1'b1;
                busy_o  = 1'b1;
                ready_o = yumi_i & last_beat;
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        wt0_d    = wt0_q;
        wt1_d    = wt1_q;
        if (state_q == DRAIN && yumi_i) begin
            if (last_beat) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // An activation accepted on the last beat overrides the return to IDLE
        if (fire) begin
            if (op_i[1]) begin
                if (op_i[0]) wt1_d = data_i;
                else         wt0_d = data_i;
            end else begin
                result_d = data_i ^ (op_i[0] ? wt1_q : wt0_q);
                cnt_d    = '0;
                state_d  = DRAIN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            wt0_q    <= '0;
            wt1_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            wt0_q    <= wt0_d;
            wt1_q    <= wt1_d;
        end
    end

`ifndef SYNTHESIS
    a_yumi_needs_v: assert property (
        @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
    a_hold_until_fire: assert property (
        @(posedge clk_i) disable iff (reset_i)
        (v_i && !ready_o) |=> (v_i && $stable(op_i)));
`endif

endmodule

// File: tb/tb_bp_be_accel_xor_array.sv
// Directed bench for bp_be_accel_xor_array with a beat scoreboard.
module tb_bp_be_accel_xor_array;
    localparam int BW = 512;
    localparam int DW = 64;
    localparam int NB = BW / DW;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [1:0]    op_i;
    logic [BW-1:0] data_i;
    logic          v_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          v_o;
    logic          yumi_i;
    logic          busy_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb[$];
    logic [BW-1:0] wm0, wm1;
    logic          fired;

    bp_be_accel_xor_array #(.block_width_p(BW), .data_width_p(DW)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .op_i   (op_i),
        .data_i (data_i),
        .v_i    (v_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .v_o    (v_o),
        .yumi_i (yumi_i),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at negedge, update model, advance past posedge
    task automatic tick();
        logic          exp_v;
        logic          exp_rdy;
        logic [DW-1:0] e;
        logic [BW-1:0] r;
        @(negedge clk_i);
        fired   = 1'b0;
        exp_v   = (sb.size() != 0);
        exp_rdy = (sb.size() == 0) || (sb.size() == 1 && yumi_i);
        chk("v_o", 64'(v_o), 64'(exp_v));
        chk("busy_o", 64'(busy_o), 64'(exp_v));
        chk("ready_o", 64'(ready_o), 64'(exp_rdy));
        if (!reset_i && yumi_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("data_o", data_o, e);
            end
        end
        if (!reset_i && v_i && exp_rdy) begin
            fired = 1'b1;
            if (op_i[1]) begin
                if (op_i[0]) wm1 = data_i;
                else         wm0 = data_i;
            end else begin
                r = data_i ^ (op_i[0] ? wm1 : wm0);
                for (int b = 0; b < NB; b++) sb.push_back(r[b*DW +: DW]);
            end
        end
        if (reset_i) begin
            sb.delete();
            wm0 = '0;
            wm1 = '0;
        end
        @(posedge clk_i);
        #1;
        if (fired) v_i = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [BW-1:0] d);
        int n;
        op_i   = op;
        data_i = d;
        v_i    = 1'b1;
        n      = 0;
        while (v_i && n < 40) begin
            tick();
            n++;
        end
        if (v_i) begin
            chk("issue_timeout", 64'(1), 64'(0));
            v_i = 1'b0;
        end
    endtask

    // mode 0: yumi every cycle; mode 1: yumi pattern 1,0,0 repeating
    task automatic drain(input int mode);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            yumi_i = (mode == 0) ? 1'b1 : (k % 3 == 0);
            tick();
            k++;
        end
        yumi_i = 1'b0;
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [BW-1:0] d;
        reset_i = 1'b1;
        v_i     = 1'b0;
        op_i    = 2'b00;
        data_i  = '0;
        yumi_i  = 1'b0;
        wm0     = '0;
        wm1     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        tick();

        issue(2'b10, {64{8'hA5}});
        issue(2'b00, {64{8'hFF}});
        drain(0);
        tick();

        for (int b = 0; b < NB; b++) d[b*DW +: DW] = 64'(b) * 64'h0101_0101;
        issue(2'b00, d);
        drain(1);
        tick();

        issue(2'b00, {8{64'h0123_4567_89AB_CDEF}});
        op_i   = 2'b00;
        data_i = {8{64'hFEDC_BA98_7654_3210}};
        v_i    = 1'b1;
        drain(0);
        chk("b2b_v_i_cleared", 64'(v_i), 64'(0));
        tick();

        issue(2'b00, {16{32'hDEAD_BEEF}});
        yumi_i = 1'b1;
        repeat (4) tick();
        yumi_i  = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tick();
        issue(2'b00, {16{32'h1357_9BDF}});
        drain(0);

        issue(2'b11, {8{64'h1}});
        for (int b = 0; b < NB; b++) d[b*DW +: DW] = 64'(b);
        issue(2'b00, d);
        drain(0);
        issue(2'b01, d);
        drain(0);

        issue(2'b01, {8{64'hCAFE_F00D_0000_FFFF}});
        yumi_i = 1'b1;
        tick();
        tick();
        op_i   = 2'b10;
        data_i = {8{64'h00FF_00FF_00FF_00FF}};
        v_i    = 1'b1;
        drain(0);
        chk("wt_v_i_cleared", 64'(v_i), 64'(0));
        issue(2'b00, {8{64'hFFFF_0000_FFFF_0000}});
        drain(0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
